fetch_controller: RTL and testbench

- Sequences the 32-bit program counter for instruction fetch. It drives the counter's `pc_sel`/`imm` controls and issues one-at-a-time requests to instruction memory.
- It buffers one fetched instruction for decode and applies branch/jump redirects from execute, discarding stale in-flight responses.
- Sits between the program counter, instruction memory and decode.

---
 rtl/fetch_controller.sv | 110 +++++++++++
 tb/tb_fetch_controller.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: steers the external PC, issues one imem request at a time, buffers one instruction for decode.
// Requests are held back while the decode buffer is full and not draining; redirects flush the buffer and drop stale responses.
module fetch_controller #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        pc_in,
  output logic [1:0]         pc_sel,
  output logic [31:0]        pc_imm,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [31:0]        imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [31:0]        imem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [31:0]        instr_data,
  output logic [31:0]        instr_pc,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_target,
  output logic [COUNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {BOOT, REQ, WAIT, DRAIN} state_t;

  localparam logic [1:0] SEL_ZERO = 2'b11;
  localparam logic [1:0] SEL_INC4 = 2'b00;
  localparam logic [1:0] SEL_HOLD = 2'b01;
  localparam logic [1:0] SEL_LOAD = 2'b10;

  state_t      state, state_nxt;
  logic [31:0] req_pc;
  logic        redir;
  logic        req_hs;
  logic        rsp_take;

  always_comb begin
    state_nxt      = state;
    pc_sel         = SEL_HOLD;
    pc_imm         = '0;
    imem_req_valid = 1'b0;
    imem_req_addr  = pc_in;
    req_hs         = 1'b0;
    rsp_take       = 1'b0;
    redir          = redirect_valid && (state != BOOT);

    case (state)
      BOOT: begin
        pc_sel    = SEL_ZERO;
        state_nxt = REQ;
      end
      REQ: begin
        // Only issue when the buffer is guaranteed free by the time the response lands.
        imem_req_valid = !instr_valid || instr_ready;
        req_hs         = imem_req_valid && imem_req_ready;
        if (req_hs) begin
          pc_sel    = SEL_INC4;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          rsp_take  = !redir;
          state_nxt = REQ;
        end
      end
      DRAIN: begin
        if (imem_rsp_valid) state_nxt = REQ;
      end
      default: state_nxt = BOOT;
    endcase

    // An accepted request cannot be revoked, so its response must be drained.
    if (redir) begin
      pc_sel = SEL_LOAD;
      pc_imm = redirect_target;
      if (state == REQ) state_nxt = req_hs ? DRAIN : REQ;
      else              state_nxt = imem_rsp_valid ? REQ : DRAIN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_pc      <= '0;
      instr_valid <= 1'b0;
      instr_data  <= '0;
      instr_pc    <= '0;
      fetch_count <= '0;
    end else begin
      if (req_hs) req_pc <= pc_in;
      if (instr_valid && instr_ready) fetch_count <= fetch_count + COUNT_W'(1);
      if (redir) begin
        instr_valid <= 1'b0;
      end else if (rsp_take) begin
        instr_valid <= 1'b1;
        instr_data  <= imem_rsp_data;
        instr_pc    <= req_pc;
      end else if (instr_valid && instr_ready) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: external PC register and one-outstanding memory around the DUT,
// abstract fetch model compared every cycle, plus directed scenarios with literal expectations.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_in;
  logic [1:0]  pc_sel;
  logic [31:0] pc_imm;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [3:0]  fetch_count;

  always #5 clk = ~clk;

  fetch_controller #(.COUNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_sel(pc_sel), .pc_imm(pc_imm),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target), .fetch_count(fetch_count)
  );

  int errs = 0;
  int checks = 0;

  // Environment: PC register driven by pc_sel, memory with one pending request.
  logic [31:0] pc_nxt;
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat_cfg;
  logic [31:0] deliv[$];
  logic [31:0] hs_addrs[$];

  // Model: booting flag, request outstanding, response to be dropped, one-entry buffer.
  bit          m_boot, m_out, m_stale, m_bv;
  logic [31:0] m_bd, m_bpc, m_rpc, m_fetch;
  int          m_cnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd3) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errs++;
    $display("FAIL %s timeout got=none exp=event", name);
  endtask

  task automatic model_reset();
    m_boot = 0; m_out = 0; m_stale = 0; m_bv = 0;
    m_bd = '0; m_bpc = '0; m_rpc = '0; m_fetch = '0; m_cnt = 0;
    mem_busy = 0; mem_cnt = 0;
  endtask

  // One clock cycle: compare at negedge, advance model/environment, drive memory response after posedge.
  task automatic step();
    logic [1:0]  e_sel;
    logic [31:0] e_imm;
    logic        e_rv, e_hs, redir, consumed, got_rsp, deliver;
    @(negedge clk);
    redir = redirect_valid && !m_boot;
    if (m_boot) begin
      e_sel = 2'b11; e_imm = '0; e_rv = 1'b0;
    end else begin
      e_rv  = !m_out && (!m_bv || instr_ready);
      e_sel = redir ? 2'b10 : ((e_rv && imem_req_ready) ? 2'b00 : 2'b01);
      e_imm = redir ? redirect_target : 32'h0;
    end
    e_hs = e_rv && imem_req_ready;

    chk("pc_sel", 32'(pc_sel), 32'(e_sel));
    chk("pc_imm", pc_imm, e_imm);
    chk("req_valid", 32'(imem_req_valid), 32'(e_rv));
    if (e_rv) chk("req_addr", imem_req_addr, m_fetch);
    chk("instr_valid", 32'(instr_valid), 32'(m_bv));
    if (m_bv) begin
      chk("instr_data", instr_data, m_bd);
      chk("instr_pc", instr_pc, m_bpc);
    end
    chk("fetch_count", 32'(fetch_count), 32'(m_cnt));

    if (instr_valid && instr_ready) deliv.push_back(instr_pc);
    if (imem_req_valid && imem_req_ready) begin
      hs_addrs.push_back(imem_req_addr);
      mem_busy = 1;
      mem_cnt  = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 3));
      mem_addr = imem_req_addr;
    end
    case (pc_sel)
      2'b11:   pc_nxt = 32'h0;
      2'b00:   pc_nxt = pc_in + 32'd4;
      2'b01:   pc_nxt = pc_in + pc_imm;
      default: pc_nxt = pc_imm;
    endcase

    if (m_boot) begin
      m_boot  = 0;
      m_fetch = 32'h0;
    end else begin
      consumed = m_bv && instr_ready;
      if (consumed) m_cnt = (m_cnt + 1) % 16;
      got_rsp = imem_rsp_valid && m_out;
      deliver = got_rsp && !m_stale && !redir;
      if (got_rsp) begin m_out = 0; m_stale = 0; end
      if (e_hs) begin
        m_out = 1; m_stale = 0; m_rpc = m_fetch; m_fetch = m_fetch + 32'd4;
      end
      if (redir) begin
        if (m_out) m_stale = 1;
        m_fetch = redirect_target;
        m_bv = 0;
      end else if (deliver) begin
        m_bv = 1; m_bd = mem_word(m_rpc); m_bpc = m_rpc;
      end else if (consumed) begin
        m_bv = 0;
      end
    end

    @(posedge clk);
    #1;
    pc_in = pc_nxt;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mem_busy = 0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_addr);
      end
    end
  endtask

  task automatic wait_hs(input string name, input bit do_chk, input logic [31:0] exp);
    int n0, k;
    n0 = hs_addrs.size();
    k = 0;
    while (hs_addrs.size() == n0 && k < 80) begin step(); k++; end
    if (hs_addrs.size() == n0) timeout(name);
    else if (do_chk) chk(name, hs_addrs[n0], exp);
  endtask

  task automatic wait_deliver(input string name, input logic [31:0] exp);
    int n0, k;
    n0 = deliv.size();
    k = 0;
    while (deliv.size() == n0 && k < 80) begin step(); k++; end
    if (deliv.size() == n0) timeout(name);
    else chk(name, deliv[n0], exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n0;
    rst_n = 0; pc_in = 32'h44; imem_req_ready = 1; imem_rsp_valid = 0; imem_rsp_data = '0;
    instr_ready = 0; redirect_valid = 0; redirect_target = '0; lat_cfg = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr_data", instr_data, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_count", 32'(fetch_count), 32'h0);
    rst_n = 1; m_boot = 1;
    #1;
    chk("boot_sel", 32'(pc_sel), 32'h3);
    chk("boot_req", 32'(imem_req_valid), 32'h0);

    // Stall: decode not ready after the first fill.
    k = 0;
    while (!instr_valid && k < 20) begin step(); k++; end
    repeat (3) step();
    #1;
    chk("stall_req", 32'(imem_req_valid), 32'h0);
    chk("stall_pc", pc_in, 32'h4);
    chk("stall_ipc", instr_pc, 32'h0);
    chk("stall_data", instr_data, mem_word(32'h0));
    instr_ready = 1;
    #1;
    chk("resume_req", 32'(imem_req_valid), 32'h1);
    chk("resume_addr", imem_req_addr, 32'h4);
    k = 0;
    while (deliv.size() < 4 && k < 60) begin step(); k++; end
    if (deliv.size() < 4) timeout("seq_deliv");
    else begin
      chk("seq_pc0", deliv[0], 32'h0);
      chk("seq_pc1", deliv[1], 32'h4);
      chk("seq_pc2", deliv[2], 32'h8);
      chk("seq_pc3", deliv[3], 32'hC);
      chk("seq_count", 32'(fetch_count), 32'h4);
    end

    // Redirect while waiting on a 3-cycle response.
    lat_cfg = 3;
    wait_hs("pre100_hs", 0, 32'h0);
    redirect_valid = 1; redirect_target = 32'h100;
    #1;
    chk("r100_sel", 32'(pc_sel), 32'h2);
    chk("r100_imm", pc_imm, 32'h100);
    step();
    redirect_valid = 0;
    wait_hs("r100_addr", 1, 32'h100);
    wait_deliver("r100_deliv", 32'h100);

    // Redirect coincident with the response.
    lat_cfg = 2;
    wait_hs("pre200_hs", 0, 32'h0);
    k = 0;
    while (!imem_rsp_valid && k < 10) begin step(); k++; end
    redirect_valid = 1; redirect_target = 32'h200;
    step();
    redirect_valid = 0;
    #1;
    chk("r200_drop", 32'(instr_valid), 32'h0);
    wait_hs("r200_addr", 1, 32'h200);

    // Redirect coincident with the request handshake, then again while draining.
    lat_cfg = 3;
    k = 0;
    while (!(imem_req_valid && imem_req_ready) && k < 40) begin step(); #1; k++; end
    redirect_valid = 1; redirect_target = 32'h300;
    step();
    redirect_target = 32'h400;
    step();
    redirect_valid = 0;
    wait_hs("r400_addr", 1, 32'h400);
    wait_deliver("r400_deliv", 32'h400);

    // Reset while waiting; responses during reset and boot must be ignored.
    wait_hs("prerst_hs", 0, 32'h0);
    rst_n = 0;
    model_reset();
    imem_rsp_valid = 1; imem_rsp_data = 32'hBAD0_BAD0;
    #1;
    chk("mrst_valid", 32'(instr_valid), 32'h0);
    chk("mrst_count", 32'(fetch_count), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1; m_boot = 1; imem_rsp_valid = 1;
    #1;
    chk("mrst_boot_sel", 32'(pc_sel), 32'h3);
    step();
    wait_hs("mrst_restart", 1, 32'h0);
    chk("mrst_count2", 32'(fetch_count), 32'h0);

    // Counter wrap with a 4-bit counter.
    lat_cfg = 1;
    n0 = deliv.size();
    k = 0;
    while (deliv.size() - n0 < 17 && k < 200) begin step(); k++; end
    if (deliv.size() - n0 < 17) timeout("wrap_deliv");
    else chk("wrap_count", 32'(fetch_count), 32'h1);

    // Randomized traffic.
    lat_cfg = 0;
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready  = ($urandom_range(0, 9) < 7);
      instr_ready     = ($urandom_range(0, 9) < 6);
      redirect_valid  = ($urandom_range(0, 11) == 0);
      redirect_target = 32'($urandom_range(0, 1023)) << 2;
      step();
    end
    redirect_valid = 0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
